// File: rtl/raster_to_blocks_if.sv
// AXI4-Stream bundle shared by the raster and block-order pixel paths.
interface axi4_stream_if #(
  parameter int DATA_W = 8
) ();
  localparam int KEEP_W = (DATA_W + 7) / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tuser;
  logic              tlast;

  modport master (output tvalid, tdata, tkeep, tstrb, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tstrb, tuser, tlast, output tready);
endinterface

// File: rtl/raster_to_blocks.sv
// Raster-to-block reorder: ping-pong stripe buffers written in raster order
// and read back as MAT_SIZE x MAT_SIZE blocks, one pixel per beat.
module raster_to_blocks #(
  parameter int PX_WIDTH    = 8,
  parameter int MAT_SIZE    = 8,
  parameter int FRAME_WIDTH = 1920
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master video_o,
  output logic          line_err_o
);
  localparam int STRIPE_PX = MAT_SIZE * FRAME_WIDTH;
  localparam int ADDR_W    = $clog2(STRIPE_PX);
  localparam int COL_W     = $clog2(FRAME_WIDTH);
  localparam int LINE_W    = $clog2(MAT_SIZE);
  localparam int BLK_N     = FRAME_WIDTH / MAT_SIZE;
  localparam int BLK_W     = (BLK_N > 1) ? $clog2(BLK_N) : 1;
  localparam int OUT_W     = ((PX_WIDTH + 7) / 8) * 8;

  typedef enum logic [1:0] {
    WRITE_BUF_0     = 2'd0,
    WAIT_BUF_1_FREE = 2'd1,
    WRITE_BUF_1     = 2'd2,
    WAIT_BUF_0_FREE = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    WAIT_BUF_0_FULL = 2'd0,
    READ_BUF_0      = 2'd1,
    WAIT_BUF_1_FULL = 2'd2,
    READ_BUF_1      = 2'd3
  } rd_state_t;

  logic [PX_WIDTH-1:0] mem0_r [STRIPE_PX];
  logic [PX_WIDTH-1:0] mem1_r [STRIPE_PX];

  wr_state_t           wr_state_r, wr_state_s;
  logic                wr_ready_r;
  logic [COL_W-1:0]    col_r, col_s, eff_col_s;
  logic [LINE_W-1:0]   line_r, line_s, eff_line_s;
  logic [1:0]          full_r, sof_r;
  logic                line_err_r;
  logic                wr_hs_s, wr_buf_s, restart_s, col_end_s, eol_s, err_s, stripe_done_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [1:0]          set_full_s, sof_set_s, free_s;

  rd_state_t           rd_state_r, rd_state_s;
  logic [BLK_W-1:0]    blk_r, blk_s;
  logic [LINE_W-1:0]   row_r, row_s, rcol_r, rcol_s;
  logic                dpr_s, rd_active_s, rd_buf_s, rd_issue_s, rd_last_s, rd_first_s;
  logic                c_end_s, r_end_s, b_end_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [1:0]          rel_s, avail_s;

  logic [PX_WIDTH-1:0] rd_data_r;
  logic                rd_vld_r, rd_user_r, rd_tlast_r;
  logic                tvalid_r, tuser_r, tlast_r;
  logic [OUT_W-1:0]    tdata_r;

  // Write datapath: a tuser pixel mid-stripe is treated as line 0, col 0.
  always_comb begin
    wr_hs_s   = video_i.tvalid && wr_ready_r;
    wr_buf_s  = (wr_state_r == WRITE_BUF_1);
    restart_s = wr_hs_s && video_i.tuser &&
                ((line_r != {LINE_W{1'b0}}) || (col_r != {COL_W{1'b0}}));
    if (restart_s) begin
      eff_col_s  = {COL_W{1'b0}};
      eff_line_s = {LINE_W{1'b0}};
    end else begin
      eff_col_s  = col_r;
      eff_line_s = line_r;
    end
    col_end_s     = (eff_col_s == COL_W'(FRAME_WIDTH - 1));
    eol_s         = video_i.tlast || col_end_s;
    err_s         = wr_hs_s && (video_i.tlast != col_end_s);
    wr_addr_s     = ADDR_W'(eff_line_s) * ADDR_W'(FRAME_WIDTH) + ADDR_W'(eff_col_s);
    stripe_done_s = wr_hs_s && eol_s && (eff_line_s == LINE_W'(MAT_SIZE - 1));
    col_s  = col_r;
    line_s = line_r;
    if (wr_hs_s) begin
      if (eol_s) begin
        col_s  = {COL_W{1'b0}};
        line_s = stripe_done_s ? {LINE_W{1'b0}} : eff_line_s + LINE_W'(1);
      end else begin
        col_s  = eff_col_s + COL_W'(1);
        line_s = eff_line_s;
      end
    end else begin
      col_s  = col_r;
      line_s = line_r;
    end
    set_full_s = stripe_done_s ? (wr_buf_s ? 2'b10 : 2'b01) : 2'b00;
    sof_set_s  = (wr_hs_s && video_i.tuser) ? (wr_buf_s ? 2'b10 : 2'b01) : 2'b00;
  end

  // Read sequencing: block, then row, then column within the stripe.
  always_comb begin
    rd_active_s = (rd_state_r == READ_BUF_0) || (rd_state_r == READ_BUF_1);
    rd_buf_s    = (rd_state_r == READ_BUF_1);
    dpr_s       = !tvalid_r || video_o.tready;
    rd_issue_s  = rd_active_s && dpr_s;
    c_end_s     = (rcol_r == LINE_W'(MAT_SIZE - 1));
    r_end_s     = (row_r == LINE_W'(MAT_SIZE - 1));
    b_end_s     = (blk_r == BLK_W'(BLK_N - 1));
    rd_last_s   = rd_issue_s && c_end_s && r_end_s && b_end_s;
    rd_first_s  = (blk_r == {BLK_W{1'b0}}) && (row_r == {LINE_W{1'b0}}) &&
                  (rcol_r == {LINE_W{1'b0}});
    rd_addr_s   = ADDR_W'(row_r) * ADDR_W'(FRAME_WIDTH) +
                  ADDR_W'(blk_r) * ADDR_W'(MAT_SIZE) + ADDR_W'(rcol_r);
    rel_s       = rd_last_s ? (rd_buf_s ? 2'b10 : 2'b01) : 2'b00;
    avail_s     = full_r | set_full_s;
    blk_s  = blk_r;
    row_s  = row_r;
    rcol_s = rcol_r;
    if (rd_issue_s) begin
      if (c_end_s) begin
        rcol_s = {LINE_W{1'b0}};
        if (r_end_s) begin
          row_s = {LINE_W{1'b0}};
          blk_s = b_end_s ? {BLK_W{1'b0}} : blk_r + BLK_W'(1);
        end else begin
          row_s = row_r + LINE_W'(1);
        end
      end else begin
        rcol_s = rcol_r + LINE_W'(1);
      end
    end else begin
      rcol_s = rcol_r;
    end
    rd_state_s = rd_state_r;
    case (rd_state_r)
      WAIT_BUF_0_FULL: if (avail_s[0]) rd_state_s = READ_BUF_0; else rd_state_s = rd_state_r;
      READ_BUF_0:      if (rd_last_s) rd_state_s = avail_s[1] ? READ_BUF_1 : WAIT_BUF_1_FULL;
                       else rd_state_s = rd_state_r;
      WAIT_BUF_1_FULL: if (avail_s[1]) rd_state_s = READ_BUF_1; else rd_state_s = rd_state_r;
      READ_BUF_1:      if (rd_last_s) rd_state_s = avail_s[0] ? READ_BUF_0 : WAIT_BUF_0_FULL;
                       else rd_state_s = rd_state_r;
      default:         rd_state_s = WAIT_BUF_0_FULL;
    endcase
  end

  // Write FSM next state; a buffer released this cycle already counts as free.
  always_comb begin
    free_s     = ~full_r | rel_s;
    wr_state_s = wr_state_r;
    case (wr_state_r)
      WRITE_BUF_0:     if (stripe_done_s) wr_state_s = free_s[1] ? WRITE_BUF_1 : WAIT_BUF_1_FREE;
                       else wr_state_s = wr_state_r;
      WAIT_BUF_1_FREE: if (free_s[1]) wr_state_s = WRITE_BUF_1; else wr_state_s = wr_state_r;
      WRITE_BUF_1:     if (stripe_done_s) wr_state_s = free_s[0] ? WRITE_BUF_0 : WAIT_BUF_0_FREE;
                       else wr_state_s = wr_state_r;
      WAIT_BUF_0_FREE: if (free_s[0]) wr_state_s = WRITE_BUF_0; else wr_state_s = wr_state_r;
      default:         wr_state_s = WRITE_BUF_0;
    endcase
  end

  // Stripe RAMs: contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_hs_s) begin
      if (wr_buf_s) mem1_r[wr_addr_s] <= video_i.tdata[PX_WIDTH-1:0];
      else          mem0_r[wr_addr_s] <= video_i.tdata[PX_WIDTH-1:0];
    end
    if (rd_issue_s) rd_data_r <= rd_buf_s ? mem1_r[rd_addr_s] : mem0_r[rd_addr_s];
  end

  // Control state, buffer flags and counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_state_r <= WRITE_BUF_0;
      rd_state_r <= WAIT_BUF_0_FULL;
      wr_ready_r <= 1'b0;
      col_r      <= {COL_W{1'b0}};
      line_r     <= {LINE_W{1'b0}};
      full_r     <= 2'b00;
      sof_r      <= 2'b00;
      line_err_r <= 1'b0;
      blk_r      <= {BLK_W{1'b0}};
      row_r      <= {LINE_W{1'b0}};
      rcol_r     <= {LINE_W{1'b0}};
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
      wr_ready_r <= (wr_state_s == WRITE_BUF_0) || (wr_state_s == WRITE_BUF_1);
      col_r      <= col_s;
      line_r     <= line_s;
      full_r     <= (full_r & ~rel_s) | set_full_s;
      sof_r      <= (sof_r | sof_set_s) & ~rel_s;
      line_err_r <= err_s;
      blk_r      <= blk_s;
      row_r      <= row_s;
      rcol_r     <= rcol_s;
    end
  end

  // Read pipeline (RAM register, then output register) advances in lockstep.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_vld_r   <= 1'b0;
      rd_user_r  <= 1'b0;
      rd_tlast_r <= 1'b0;
      tvalid_r   <= 1'b0;
      tuser_r    <= 1'b0;
      tlast_r    <= 1'b0;
      tdata_r    <= {OUT_W{1'b0}};
    end else if (dpr_s) begin
      rd_vld_r   <= rd_issue_s;
      rd_user_r  <= rd_issue_s && rd_first_s && sof_r[rd_buf_s];
      rd_tlast_r <= rd_issue_s && c_end_s && r_end_s;
      tvalid_r   <= rd_vld_r;
      tuser_r    <= rd_vld_r && rd_user_r;
      tlast_r    <= rd_vld_r && rd_tlast_r;
      if (rd_vld_r) tdata_r <= OUT_W'(rd_data_r);
    end
  end

  assign video_i.tready = wr_ready_r;
  assign video_o.tvalid = tvalid_r;
  assign video_o.tdata  = tdata_r;
  assign video_o.tuser  = tuser_r;
  assign video_o.tlast  = tlast_r;
  assign video_o.tkeep  = {(OUT_W / 8){1'b1}};
  assign video_o.tstrb  = {(OUT_W / 8){1'b1}};
  assign line_err_o     = line_err_r;

endmodule

// File: tb/tb_raster_to_blocks.sv
// Scoreboard bench for raster_to_blocks with a 16-pixel line and 8x8 blocks.
module tb_raster_to_blocks;
  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  logic clk, rst_n, line_err;
  axi4_stream_if #(.DATA_W(8)) vin ();
  axi4_stream_if #(.DATA_W(8)) vout ();

  raster_to_blocks #(.PX_WIDTH(8), .MAT_SIZE(8), .FRAME_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .video_i(vin.slave), .video_o(vout.master),
    .line_err_o(line_err)
  );

  beat_t      exp_q[$];
  logic [7:0] mdl [2][128];
  bit         msof [2];
  int mb, ml, mc;
  int total, bad, cyc, beats, err_seen, exp_err, mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model of the stripe writer; queues a stripe's beats on completion.
  task automatic model_px(input logic [7:0] d, input logic u, input logic l);
    if (u && (ml != 0 || mc != 0)) begin
      ml = 0;
      mc = 0;
    end
    if (u) msof[mb] = 1'b1;
    if (l != (mc == 15)) exp_err++;
    mdl[mb][ml*16+mc] = d;
    if (l || mc == 15) begin
      mc = 0;
      if (ml == 7) begin
        for (int b = 0; b < 2; b++)
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              exp_q.push_back('{d: mdl[mb][r*16+b*8+c],
                                u: (b == 0 && r == 0 && c == 0 && msof[mb]),
                                l: (r == 7 && c == 7)});
        msof[mb] = 1'b0;
        ml = 0;
        mb = 1 - mb;
      end else begin
        ml++;
      end
    end else begin
      mc++;
    end
  endtask

  task automatic send_px(input logic [7:0] d, input logic u, input logic l);
    int n;
    vin.tvalid = 1'b1;
    vin.tdata  = d;
    vin.tuser  = u;
    vin.tlast  = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vin.tready && n < 2000);
    if (!vin.tready) begin
      chk("in_accept_timeout", {31'd0, vin.tready}, 32'd1);
      vin.tvalid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      model_px(d, u, l);
    end
  endtask

  task automatic send_lines(input int first, input int n, input bit sof);
    for (int l = first; l < first + n; l++)
      for (int c = 0; c < 16; c++)
        send_px(8'((l * 16 + c) % 256), sof && l == first && c == 0, c == 15);
    vin.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-ready pattern: 0 = always ready, 1 = random, other = held low.
  initial begin
    vout.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       vout.tready = 1'b1;
        1:       vout.tready = 1'($urandom_range(0, 1));
        default: vout.tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare, stall stability and error pulse count.
  initial begin
    bit         stall;
    logic [9:0] held;
    beat_t      e;
    stall = 1'b0;
    held  = 10'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_tvalid", {31'd0, vout.tvalid}, 32'd1);
          chk("hold_beat", {22'd0, vout.tuser, vout.tlast, vout.tdata}, {22'd0, held});
        end
        if (vout.tvalid && vout.tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            chk("extra_beat", {24'd0, vout.tdata}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", {24'd0, vout.tdata}, {24'd0, e.d});
            chk("tuser", {31'd0, vout.tuser}, {31'd0, e.u});
            chk("tlast", {31'd0, vout.tlast}, {31'd0, e.l});
          end
        end
        stall = vout.tvalid && !vout.tready;
        held  = {vout.tuser, vout.tlast, vout.tdata};
        if (line_err) err_seen++;
      end
    end
  end

  initial begin
    int start, base, n;
    mode = 0;
    mb = 0; ml = 0; mc = 0;
    msof[0] = 1'b0; msof[1] = 1'b0;
    vin.tvalid = 1'b0; vin.tdata = 8'd0; vin.tuser = 1'b0; vin.tlast = 1'b0;
    vin.tkeep = 1'b1; vin.tstrb = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'd0, vout.tvalid}, 32'd0);
    chk("rst_tuser", {31'd0, vout.tuser}, 32'd0);
    chk("rst_tlast", {31'd0, vout.tlast}, 32'd0);
    chk("rst_tdata", {24'd0, vout.tdata}, 32'd0);
    chk("rst_line_err", {31'd0, line_err}, 32'd0);
    chk("rst_in_tready", {31'd0, vin.tready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic stripe, full rate, latency and output rate.
    start = cyc;
    send_lines(0, 8, 1'b1);
    chk("in_rate_cycles", cyc - start, 32'd128);
    @(posedge clk); #1;
    chk("latency_cycle1_tvalid", {31'd0, vout.tvalid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_cycle2_tvalid", {31'd0, vout.tvalid}, 32'd1);
    base = beats;
    repeat (128) @(negedge clk);
    #1;
    chk("out_rate_beats", beats - base, 32'd128);
    drain();

    // Same stripe with random back-pressure.
    mode = 1;
    send_lines(0, 8, 1'b1);
    drain();

    // Three stripes with output held off.
    mode = 2;
    send_lines(0, 8, 1'b1);
    send_lines(8, 8, 1'b0);
    @(negedge clk);
    chk("in_tready_dropped", {31'd0, vin.tready}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("in_tready_still_low", {31'd0, vin.tready}, 32'd0);
    mode = 0;
    send_lines(16, 8, 1'b0);
    drain();

    // Short line 3 (tlast at col 9) and line 6 without tlast.
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < ((l == 3) ? 10 : 16); c++)
        send_px(8'((l * 16 + c) % 256), l == 0 && c == 0,
                (l == 3) ? (c == 9) : ((l == 6) ? 1'b0 : (c == 15)));
    vin.tvalid = 1'b0;
    drain();
    chk("line_err_pulses", err_seen, exp_err);

    // Start of frame mid-stripe at line 5 col 4.
    send_lines(0, 5, 1'b1);
    for (int c = 0; c < 4; c++) send_px(8'((80 + c) % 256), 1'b0, 1'b0);
    send_px(8'hA5, 1'b1, 1'b0);
    for (int c = 1; c < 16; c++) send_px(8'(c + 3), 1'b0, c == 15);
    for (int l = 1; l < 8; l++)
      for (int c = 0; c < 16; c++) send_px(8'((l * 16 + c + 3) % 256), 1'b0, c == 15);
    vin.tvalid = 1'b0;
    drain();

    // Reset during readout.
    base = beats;
    send_lines(0, 8, 1'b1);
    n = 0;
    while (beats - base < 20 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    chk("pre_rst_tvalid", {31'd0, vout.tvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", {31'd0, vout.tvalid}, 32'd0);
    chk("async_rst_in_tready", {31'd0, vin.tready}, 32'd0);
    exp_q.delete();
    mb = 0; ml = 0; mc = 0;
    msof[0] = 1'b0; msof[1] = 1'b0;
    #9;
    rst_n = 1'b1;
    base = beats;
    send_lines(0, 5, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("no_beats_after_rst", beats - base, 32'd0);
    send_lines(5, 3, 1'b0);
    drain();
    chk("beats_after_rst", beats - base, 32'd128);
    chk("line_err_total", err_seen, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
